hilo_mdu_ctrl: RTL and testbench

Sequencer that owns all writes into the HI/LO register pair. It accepts multiply, divide and move-to-HI/LO requests from the execute stage and runs a pipelined multiplier or an iterative radix-2 divider. It then issues a single-cycle HI/LO write. While an operation is in flight it back-pressures the pipeline through req_ready/busy, and it drops in-flight work on flush.

---
 rtl/hilo_mdu_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hilo_mdu_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO write sequencer: owns every HI/LO update, running MT* moves, a
// pipelined multiply and a 32-step restoring divide with back-pressure and flush.
module hilo_mdu_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        busy,
    output logic        hi_write,
    output logic        lo_write,
    output logic [31:0] hi_data,
    output logic [31:0] lo_data
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state, state_n;
    logic [4:0]  cnt;
    logic [31:0] op_a, op_b;
    logic        mul_signed;
    logic [31:0] div_rem, div_quo;
    logic        q_neg, r_neg, div_zero;

    logic        accept, is_mul, is_div, div_signed;
    logic [31:0] a_abs, b_abs;
    logic        hi_we_n, lo_we_n;
    logic [31:0] hi_d_n, lo_d_n;

    logic signed [32:0] mul_a, mul_b;
    logic signed [63:0] product;
    logic [32:0] div_shift, div_trial;
    logic [31:0] quo_fix, rem_fix;

    assign req_ready  = (state == IDLE);
    assign busy       = ~req_ready;
    assign accept     = req_valid && req_ready && !flush;
    assign is_mul     = (req_op == OP_MULT) || (req_op == OP_MULTU);
    assign is_div     = (req_op == OP_DIV)  || (req_op == OP_DIVU);
    assign div_signed = (req_op == OP_DIV);
    assign a_abs      = (div_signed && req_a[31]) ? -req_a : req_a;
    assign b_abs      = (div_signed && req_b[31]) ? -req_b : req_b;

    // 33-bit signed operands make one multiplier serve both MULT and MULTU
    assign mul_a   = {mul_signed & op_a[31], op_a};
    assign mul_b   = {mul_signed & op_b[31], op_b};
    assign product = 64'(mul_a) * 64'(mul_b);

    assign div_shift = {div_rem, div_quo[31]};
    assign div_trial = div_shift - {1'b0, op_b};
    assign quo_fix   = div_zero ? 32'hFFFF_FFFF : (q_neg ? -div_quo : div_quo);
    assign rem_fix   = div_zero ? op_a : (r_neg ? -div_rem : div_rem);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        hi_we_n = 1'b0;
        lo_we_n = 1'b0;
        hi_d_n  = hi_data;
        lo_d_n  = lo_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mul) state_n = MUL;
                    if (is_div) state_n = DIV;
                    if (req_op == OP_MTHI) begin
                        hi_we_n = 1'b1;
                        hi_d_n  = req_a;
                    end
                    if (req_op == OP_MTLO) begin
                        lo_we_n = 1'b1;
                        lo_d_n  = req_a;
                    end
                end
            end
            MUL: begin
                if (cnt == 5'd1) begin
                    state_n = IDLE;
                    hi_we_n = 1'b1;
                    lo_we_n = 1'b1;
                    hi_d_n  = product[63:32];
                    lo_d_n  = product[31:0];
                end
            end
            DIV: begin
                if (cnt == 5'd0) state_n = FIX;
            end
            FIX: begin
                state_n = IDLE;
                hi_we_n = 1'b1;
                lo_we_n = 1'b1;
                hi_d_n  = rem_fix;
                lo_d_n  = quo_fix;
            end
            default: state_n = IDLE;
        endcase
        // A write already on the outputs is untouched; only the one being formed dies
        if (flush) begin
            state_n = IDLE;
            hi_we_n = 1'b0;
            lo_we_n = 1'b0;
            hi_d_n  = hi_data;
            lo_d_n  = lo_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_write <= 1'b0;
            lo_write <= 1'b0;
            hi_data  <= '0;
            lo_data  <= '0;
        end else begin
            hi_write <= hi_we_n;
            lo_write <= lo_we_n;
            hi_data  <= hi_d_n;
            lo_data  <= lo_d_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            mul_signed <= 1'b0;
            div_rem    <= '0;
            div_quo    <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            div_zero   <= 1'b0;
        end else if (accept && is_mul) begin
            op_a       <= req_a;
            op_b       <= req_b;
            mul_signed <= (req_op == OP_MULT);
            cnt        <= 5'(MUL_LAT - 1);
        end else if (accept && is_div) begin
            op_a     <= req_a;
            op_b     <= b_abs;
            div_rem  <= '0;
            div_quo  <= a_abs;
            q_neg    <= div_signed && (req_a[31] ^ req_b[31]);
            r_neg    <= div_signed && req_a[31];
            div_zero <= (req_b == 32'd0);
            cnt      <= 5'd31;
        end else if (state == MUL) begin
            cnt <= cnt - 5'd1;
        end else if (state == DIV) begin
            cnt <= cnt - 5'd1;
            if (!div_trial[32]) begin
                div_rem <= div_trial[31:0];
                div_quo <= {div_quo[30:0], 1'b1};
            end else begin
                div_rem <= div_shift[31:0];
                div_quo <= {div_quo[30:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Scoreboard bench for hilo_mdu_ctrl: directed requests queue their expected
// HI/LO writes; a negedge monitor matches every write pulse against the queue.
module tb_hilo_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        flush;
    logic        busy;
    logic        hi_write, lo_write;
    logic [31:0] hi_data, lo_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic        hw;
        logic        lw;
        logic [31:0] hd;
        logic [31:0] ld;
    } exp_t;

    exp_t sb[$];

    hilo_mdu_ctrl #(.MUL_LAT(3)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush), .busy(busy),
        .hi_write(hi_write), .lo_write(lo_write), .hi_data(hi_data), .lo_data(lo_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one request for one cycle; lat>0 queues the write expected lat cycles later
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int lat, input logic hw, input logic lw,
                                 input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        if (lat > 0) begin
            e.cyc = cyc + lat;
            e.hw  = hw;
            e.lw  = lw;
            e.hd  = eh;
            e.ld  = el;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'hCAFE_F00D;
        req_op    = 3'd0;
    endtask

    always @(negedge clk) begin
        if (!reset && (hi_write || lo_write)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: hw=%0b lw=%0b hi=0x%08h lo=0x%08h, none expected (cycle %0d)",
                         hi_write, lo_write, hi_data, lo_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("write_cycle", cyc, e.cyc);
                checkOutput("hi_write", {31'd0, hi_write}, {31'd0, e.hw});
                checkOutput("lo_write", {31'd0, lo_write}, {31'd0, e.lw});
                if (e.hw) checkOutput("hi_data", hi_data, e.hd);
                if (e.lw) checkOutput("lo_data", lo_data, e.ld);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = '0;
        req_b     = '0;
        flush     = 1'b0;
        waitCycles(2);
        reset = 1'b0;
        checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_hi_data", hi_data, 32'd0);
        checkOutput("rst_lo_data", lo_data, 32'd0);
        waitCycles(1);

        // MT* back-to-back
        applyStimulus(3'd5, 32'h1234_5678, 32'd0, 1, 1'b1, 1'b0, 32'h1234_5678, 32'd0);
        applyStimulus(3'd6, 32'h0BAD_F00D, 32'd0, 1, 1'b0, 1'b1, 32'd0, 32'h0BAD_F00D);
        applyStimulus(3'd0, 32'h1111_1111, 32'd0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(3'd7, 32'h2222_2222, 32'd0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        waitCycles(2);

        // Multiplies
        applyStimulus(3'd1, 32'hFFFF_FFFE, 32'd3, 3, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        checkOutput("mult_ready_t1", {31'd0, req_ready}, 32'd0);
        waitCycles(1);
        checkOutput("mult_ready_t2", {31'd0, req_ready}, 32'd0);
        waitCycles(1);
        checkOutput("mult_ready_t3", {31'd0, req_ready}, 32'd1);
        waitCycles(1);
        applyStimulus(3'd2, 32'hFFFF_FFFE, 32'd3, 3, 1'b1, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA);
        waitCycles(4);

        // Divides
        applyStimulus(3'd4, 32'd100, 32'd7, 34, 1'b1, 1'b1, 32'h0000_0002, 32'h0000_000E);
        checkOutput("div_busy_t1", {31'd0, busy}, 32'd1);
        waitCycles(32);
        checkOutput("div_busy_t33", {31'd0, busy}, 32'd1);
        waitCycles(1);
        checkOutput("div_busy_t34", {31'd0, busy}, 32'd0);
        waitCycles(1);
        applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2, 34, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        waitCycles(34);
        applyStimulus(3'd3, 32'd5, 32'd0, 34, 1'b1, 1'b1, 32'h0000_0005, 32'hFFFF_FFFF);
        waitCycles(34);
        applyStimulus(3'd4, 32'h8000_0001, 32'd0, 34, 1'b1, 1'b1, 32'h8000_0001, 32'hFFFF_FFFF);
        waitCycles(34);
        applyStimulus(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 34, 1'b1, 1'b1, 32'h0000_0000, 32'h8000_0000);
        waitCycles(34);
        applyStimulus(3'd3, 32'd7, 32'hFFFF_FFFE, 34, 1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD);
        waitCycles(34);

        // Flush mid-divide, then MTLO right after
        applyStimulus(3'd4, 32'd1000, 32'd3, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        waitCycles(9);
        flush = 1'b1;
        waitCycles(1);
        flush = 1'b0;
        checkOutput("flush_ready", {31'd0, req_ready}, 32'd1);
        applyStimulus(3'd6, 32'h0000_00A5, 32'd0, 1, 1'b0, 1'b1, 32'd0, 32'h0000_00A5);
        waitCycles(1);

        // Flush coincident with a request: not accepted
        flush = 1'b1;
        applyStimulus(3'd5, 32'h7777_7777, 32'd0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        flush = 1'b0;
        waitCycles(2);

        // Flush in the last multiply cycle cancels the product write
        applyStimulus(3'd1, 32'd9, 32'd9, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        waitCycles(1);
        flush = 1'b1;
        waitCycles(1);
        flush = 1'b0;
        waitCycles(4);

        // MTHI accepted in the product-write cycle
        applyStimulus(3'd1, 32'd6, 32'hFFFF_FFFF, 3, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        waitCycles(2);
        applyStimulus(3'd5, 32'h0000_0001, 32'd0, 1, 1'b1, 1'b0, 32'h0000_0001, 32'd0);
        waitCycles(2);

        // Reset in the middle of a divide
        applyStimulus(3'd3, 32'd50, 32'd5, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        waitCycles(5);
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        checkOutput("midrst_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("midrst_hi_data", hi_data, 32'd0);
        checkOutput("midrst_lo_data", lo_data, 32'd0);
        checkOutput("midrst_we", {30'd0, hi_write, lo_write}, 32'd0);
        waitCycles(40);

        checkOutput("sb_drain", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
